// File: rtl/seq_gen_multiphase.sv
// seq_gen_multiphase
//   Multi-phase count-sequence generator used for EVA control sequencing.
//   A run steps through NPH phases. Each phase counts up or down by one
//   until seq_no equals that phase's end value. It then loads the phase's
//   reload value and moves on to the next phase. After the last phase the
//   block pulses done for one cycle and goes back to IDLE.
//
// Optional feature (compile-time macro SEQ_GEN_LOOP_EN):
//   Adds the loop input. When loop is high at the terminal of the last
//   phase, the run restarts from START_VAL. done still pulses for that
//   cycle and busy stays high.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   start       begin a run (only honoured in IDLE)
//   abort       cancel a run, back to IDLE, no done
//   step_en     advance enable while running (0 = hold)
//   cfg_dir     per-phase direction, 1 = up
//   cfg_end     per-phase terminal value, field p at [p*W +: W]
//   cfg_reload  per-phase reload value loaded at terminal
//   loop        free-running request (SEQ_GEN_LOOP_EN only)
//   seq_no      current sequence value
//   phase       current phase index
//   state       0 IDLE, 1 RUN, 2 DONE
//   busy        high while in RUN
//   done        one-cycle completion pulse
//
// state  | meaning
// -------+---------------------------------------------
// IDLE   | waiting for start, seq_no/phase forced to 0
// RUN    | counting through phases on step_en
// DONE   | single cycle, done=1, seq_no = last reload
module seq_gen_multiphase #(
  parameter int              W         = 4,
  parameter int              NPH       = 4,
  parameter logic [W-1:0]    START_VAL = '0,
  localparam int             PW        = (NPH > 1) ? $clog2(NPH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               step_en,
  input  logic [NPH-1:0]     cfg_dir,
  input  logic [NPH*W-1:0]   cfg_end,
  input  logic [NPH*W-1:0]   cfg_reload,
`ifdef SEQ_GEN_LOOP_EN
  input  logic               loop,
`endif
  output logic [W-1:0]       seq_no,
  output logic [PW-1:0]      phase,
  output logic [1:0]         state,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0]    S_IDLE  = 2'd0;
  localparam logic [1:0]    S_RUN   = 2'd1;
  localparam logic [1:0]    S_DONE  = 2'd2;
  localparam logic [PW-1:0] LAST_PH = PW'(NPH - 1);

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     seq_q, seq_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [NPH-1:0]   dir_q, dir_d;
  logic [NPH*W-1:0] end_q, end_d;
  logic [NPH*W-1:0] reload_q, reload_d;

  logic [W-1:0]     cur_end;
  logic [W-1:0]     cur_reload;
  logic             cur_dir;

  // Only the shadow copies are used in the datapath. Changes to the cfg
  // inputs during a run therefore cannot disturb the sequence.
  always_comb begin
    cur_end    = end_q[phase_q*W +: W];
    cur_reload = reload_q[phase_q*W +: W];
    cur_dir    = dir_q[phase_q];
  end

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    phase_d  = phase_q;
    done_d   = 1'b0;
    dir_d    = dir_q;
    end_d    = end_q;
    reload_d = reload_q;

    case (state_q)
      S_IDLE: begin
        seq_d   = '0;
        phase_d = '0;
        if (start) begin
          state_d  = S_RUN;
          seq_d    = START_VAL;
          dir_d    = cfg_dir;
          end_d    = cfg_end;
          reload_d = cfg_reload;
        end
      end
      S_RUN: begin
        // abort wins over both stepping and terminal detection
        if (abort) begin
          state_d = S_IDLE;
          seq_d   = '0;
          phase_d = '0;
        end else if (step_en) begin
          if (seq_q == cur_end) begin
            seq_d = cur_reload;
            if (phase_q == LAST_PH) begin
              phase_d = '0;
              done_d  = 1'b1;
`ifdef SEQ_GEN_LOOP_EN
              if (loop) begin
                seq_d = START_VAL;
              end else begin
                state_d = S_DONE;
              end
`else
              state_d = S_DONE;
`endif
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end else if (cur_dir) begin
            seq_d = seq_q + 1'b1;
          end else begin
            seq_d = seq_q - 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        seq_d   = '0;
        phase_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        seq_d   = '0;
        phase_d = '0;
      end
    endcase

    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      seq_q    <= '0;
      phase_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dir_q    <= '0;
      end_q    <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      phase_q  <= phase_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dir_q    <= dir_d;
      end_q    <= end_d;
      reload_q <= reload_d;
    end
  end

  assign seq_no = seq_q;
  assign phase  = phase_q;
  assign state  = state_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
